// File: rtl/vga_timing_gen_pkg.sv
// SVGA 800x600@72 Hz raster constants shared by the timing generator and its bench.
// Includes the helper that decodes a half-open counter window [lo, hi).
package vga_timing_gen_pkg;

    localparam int COORD_W   = 11;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    localparam int SVGA_H_VIS   = 800;
    localparam int SVGA_H_FP    = 56;
    localparam int SVGA_H_SYNC  = 120;
    localparam int SVGA_H_BP    = 64;
    localparam int SVGA_H_TOTAL = SVGA_H_VIS + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

    localparam int SVGA_V_VIS   = 600;
    localparam int SVGA_V_FP    = 37;
    localparam int SVGA_V_SYNC  = 6;
    localparam int SVGA_V_BP    = 23;
    localparam int SVGA_V_TOTAL = SVGA_V_VIS + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

    localparam bit SVGA_SYNC_POL = 1'b1;

    function automatic logic in_window(input logic [COORD_W-1:0] c,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register chain that realigns the sync pins with the renderer's colour pipeline.
// DEPTH of zero is a straight wire; every stage resets to rst_val.
module sync_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_chain
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] q_reg;
                logic [WIDTH-1:0] stage_in;

                if (gi == 0) begin : g_first
                    assign stage_in = din;
                end else begin : g_link
                    assign stage_in = g_stage[gi-1].q_reg;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= rst_val;
                    end else begin
                        q_reg <= stage_in;
                    end
                end
            end
            assign dout = g_stage[DEPTH-1].q_reg;
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster position, visible-area enable and start pulses for the renderer, plus
// HSYNC/VSYNC delayed to match the renderer's colour pipeline at the connector.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VIS      = SVGA_H_VIS,
    parameter int H_FP       = SVGA_H_FP,
    parameter int H_SYNC     = SVGA_H_SYNC,
    parameter int H_BP       = SVGA_H_BP,
    parameter int V_VIS      = SVGA_V_VIS,
    parameter int V_FP       = SVGA_V_FP,
    parameter int V_SYNC     = SVGA_V_SYNC,
    parameter int V_BP       = SVGA_V_BP,
    parameter bit SYNC_POL   = SVGA_SYNC_POL,
    parameter int SYNC_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic               display_en,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_totals
            $error("vga_timing_gen: raster totals exceed the 11-bit coordinate range");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be within 0..7");
        end
    endgenerate

    localparam logic [COORD_W-1:0] CNT_ONE = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_END   = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] V_END   = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_VIS + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_cnt_reg, v_cnt_reg;
    logic [COORD_W-1:0] h_next, v_next;
    logic               started_reg;
    logic               display_en_reg, line_start_reg, frame_start_reg;
    logic               hsync_raw_reg, vsync_raw_reg;
    logic [1:0]         sync_delayed;

    // The first edge out of reset only arms the generator, so (0,0) is presented with its pulses.
    always_comb begin
        h_next = h_cnt_reg;
        v_next = v_cnt_reg;
        if (started_reg) begin
            if (h_cnt_reg == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + CNT_ONE;
            end else begin
                h_next = h_cnt_reg + CNT_ONE;
            end
        end
    end

    // Flags are decoded from the next count so they land in the same cycle as x_pos/y_pos.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_reg     <= 1'b0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            display_en_reg  <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            hsync_raw_reg   <= ~SYNC_POL;
            vsync_raw_reg   <= ~SYNC_POL;
        end else begin
            started_reg     <= 1'b1;
            h_cnt_reg       <= h_next;
            v_cnt_reg       <= v_next;
            display_en_reg  <= (h_next < H_END) && (v_next < V_END);
            line_start_reg  <= (h_next == '0);
            frame_start_reg <= (h_next == '0) && (v_next == '0);
            hsync_raw_reg   <= in_window(h_next, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            vsync_raw_reg   <= in_window(v_next, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
        end
    end

    sync_delay_line #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (2)
    ) u_sync_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val ({~SYNC_POL, ~SYNC_POL}),
        .din     ({hsync_raw_reg, vsync_raw_reg}),
        .dout    (sync_delayed)
    );

    assign x_pos       = h_cnt_reg;
    assign y_pos       = v_cnt_reg;
    assign display_en  = display_en_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign hsync       = sync_delayed[1];
    assign vsync       = sync_delayed[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generators (SVGA with delay 2, SVGA with delay 0, a tiny inverted-sync raster)
// compared every cycle against an arithmetic raster model, with random async resets.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int S_HV = 16, S_HFP = 4, S_HS = 6, S_HBP = 4;
    localparam int S_VV = 10, S_VFP = 2, S_VS = 3, S_VBP = 2;
    localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] a_x, a_y, b_x, b_y, s_x, s_y;
    logic a_de, a_ls, a_fs, a_hs, a_vs;
    logic b_de, b_ls, b_fs, b_hs, b_vs;
    logic s_de, s_ls, s_fs, s_hs, s_vs;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .x_pos(a_x), .y_pos(a_y), .display_en(a_de),
        .line_start(a_ls), .frame_start(a_fs), .hsync(a_hs), .vsync(a_vs));

    vga_timing_gen #(.SYNC_DELAY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .x_pos(b_x), .y_pos(b_y), .display_en(b_de),
        .line_start(b_ls), .frame_start(b_fs), .hsync(b_hs), .vsync(b_vs));

    vga_timing_gen #(
        .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SYNC_POL(1'b0), .SYNC_DELAY(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .x_pos(s_x), .y_pos(s_y), .display_en(s_de),
        .line_start(s_ls), .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_mod = -1;   // pixel index since the first edge after reset release; -1 while in reset

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Expected {x, y, display_en, line_start, frame_start, hsync, vsync} for pixel index n.
    function automatic logic [26:0] ref_vec(input int n, input int hv, input int hfp, input int hs,
                                            input int hbp, input int vv, input int vfp, input int vs,
                                            input int vbp, input bit pol, input int d);
        int ht, vt, p, x, y, m;
        logic [10:0] xo, yo;
        bit de, ls, fs, hact, vact;
        ht = hv + hfp + hs + hbp;
        vt = vv + vfp + vs + vbp;
        xo = '0; yo = '0; de = 0; ls = 0; fs = 0; hact = 0; vact = 0;
        if (n >= 0) begin
            p  = n % (ht * vt);
            x  = p % ht;
            y  = p / ht;
            xo = x[10:0];
            yo = y[10:0];
            de = (x < hv) && (y < vv);
            ls = (x == 0);
            fs = (p == 0);
        end
        m = n - d;
        if (n >= 0 && m >= 0) begin
            p    = m % (ht * vt);
            x    = p % ht;
            y    = p / ht;
            hact = (x >= hv + hfp) && (x < hv + hfp + hs);
            vact = (y >= vv + vfp) && (y < vv + vfp + vs);
        end
        return {xo, yo, de, ls, fs, hact ? pol : ~pol, vact ? pol : ~pol};
    endfunction

    function automatic logic [26:0] exp_a(input int n);
        return ref_vec(n, SVGA_H_VIS, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP,
                       SVGA_V_VIS, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP, 1'b1, 2);
    endfunction
    function automatic logic [26:0] exp_b(input int n);
        return ref_vec(n, SVGA_H_VIS, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP,
                       SVGA_V_VIS, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP, 1'b1, 0);
    endfunction
    function automatic logic [26:0] exp_s(input int n);
        return ref_vec(n, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, 1'b0, 3);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_mod <= -1;
        else        n_mod <= n_mod + 1;
    end

    int b_last_ls = -1, b_hs_cnt = 0, s_last_fs = -1, s_vs_cnt = 0;
    bit b_line_seen = 0, s_frame_seen = 0;

    always @(negedge clk) begin
        cyc++;
        check_eq("dut_a", {5'd0, a_x, a_y, a_de, a_ls, a_fs, a_hs, a_vs}, {5'd0, exp_a(n_mod)});
        check_eq("dut_b", {5'd0, b_x, b_y, b_de, b_ls, b_fs, b_hs, b_vs}, {5'd0, exp_b(n_mod)});
        check_eq("dut_s", {5'd0, s_x, s_y, s_de, s_ls, s_fs, s_hs, s_vs}, {5'd0, exp_s(n_mod)});
        if (!rst_n) begin
            b_last_ls = -1; b_hs_cnt = 0; b_line_seen = 0;
            s_last_fs = -1; s_vs_cnt = 0; s_frame_seen = 0;
        end else begin
            if (b_ls) begin
                if (b_last_ls >= 0) check_eq("b_line_period", cyc - b_last_ls, SVGA_H_TOTAL);
                if (b_line_seen) check_eq("b_hsync_width", b_hs_cnt, SVGA_H_SYNC);
                b_last_ls = cyc; b_hs_cnt = 0; b_line_seen = 1;
            end
            if (b_hs) b_hs_cnt++;
            if (s_fs) begin
                if (s_last_fs >= 0) check_eq("s_frame_period", cyc - s_last_fs, S_HT * S_VT);
                if (s_frame_seen) check_eq("s_vsync_width", s_vs_cnt, S_VS * S_HT);
                s_last_fs = cyc; s_vs_cnt = 0; s_frame_seen = 1;
            end
            if (!s_vs) s_vs_cnt++;
        end
    end

    initial begin
        int run, hold;
        bit found;
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2600) @(posedge clk);

        // Last pixel of the small raster must wrap to (0,0) with a frame start.
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (s_x == 11'(S_HT - 1) && s_y == 11'(S_VT - 1)) found = 1;
        end
        check_eq("wrap_reached", 32'(found), 32'd1);
        @(negedge clk);
        check_eq("wrap_next", {s_x, s_y, s_fs, s_de}, {11'd0, 11'd0, 1'b1, 1'b1});

        for (int i = 0; i < 6; i++) begin
            run = $urandom_range(40, 1500);
            repeat (run) @(posedge clk);
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1;
            check_eq("async_rst_a", {5'd0, a_x, a_y, a_de, a_ls, a_fs, a_hs, a_vs}, {5'd0, exp_a(-1)});
            check_eq("async_rst_s", {5'd0, s_x, s_y, s_de, s_ls, s_fs, s_hs, s_vs}, {5'd0, exp_s(-1)});
            hold = $urandom_range(1, 5);
            repeat (hold) @(posedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
        end

        repeat (1200) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
